rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter FLASH_BASE, default 24'h100000: SPI flash byte address of ROM image.
REQ-002 Parameter ROM_AW, default 19: log2 of image size in bytes (512 KB).
REQ-003 Parameter SCK_DIV, default 2: clk cycles per SCK half-period; legal range 1..255.
REQ-004 clk  in  1  system clock, 25.175 MHz; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 spi_cs_n / spi_sck / spi_mosi  out  1 each  SPI flash master, mode 0.
REQ-007 spi_miso  in  1  flash serial data.
REQ-008 z88_reset_n  out  1  low until image load is complete; drives Z88 reset input.
REQ-009 done  out  1  high once load is complete.
REQ-010 rom_a  in  19; rom_ce_n, rom_oe_n  in  1: Z88 internal ROM port; rom_do  out  8.
REQ-011 ram_a  in  19; ram_di  in  8; ram_ce_n, ram_oe_n, ram_we_n  in  1: Z88 internal RAM port; ram_do  out  8.
REQ-012 sram_a  out  20; sram_dq_o  out  8; sram_dq_i  in  8; sram_dq_oe  out  1; sram_ce_n, sram_oe_n, sram_we_n  out  1: external 1 MB async SRAM.

Function
REQ-013 FSM states IDLE, CMD, READ, WRITE, DONE; IDLE entered on reset.
REQ-014 IDLE -> CMD on first clk after reset release; spi_cs_n goes low on that same edge.
REQ-015 CMD shifts 32 bits MSB first: 8'h03 then FLASH_BASE[23:0]; mosi changes only while SCK low, flash samples on SCK rise.
REQ-016 SCK idles low; each half-period lasts exactly SCK_DIV clk cycles; one 8-bit byte = 16*SCK_DIV clk.
REQ-017 READ samples spi_miso on each SCK rising edge, MSB first, into an 8-bit shift register; after 8 bits -> WRITE with SCK held low.
REQ-018 WRITE: sram_a = {1'b0, byte counter}, sram_dq_o = byte, sram_dq_oe=1, sram_ce_n=0, sram_we_n=0 for 2 clk, then sram_we_n=1 for 1 clk (data held), then -> READ.
REQ-019 cs_n stays low across the whole transfer (single continuous read command); SCK does not toggle in WRITE.
REQ-020 Byte counter is ROM_AW bits, starts at 0, increments after each WRITE; WRITE of counter = 2^ROM_AW-1 -> DONE instead of READ, counter wraps to 0, cs_n=1.
REQ-021 DONE is terminal until reset; done=1 and z88_reset_n=1 registered, asserted on entry to DONE.
REQ-022 In DONE, memory path is combinational pass-through:
- ROM access (rom_ce_n=0): sram_a={1'b0,rom_a}, sram_ce_n=0, sram_oe_n=rom_oe_n, sram_we_n=1, sram_dq_oe=0.
- RAM access (ram_ce_n=0, rom_ce_n=1): sram_a={1'b1,ram_a}, sram_oe_n=ram_oe_n, sram_we_n=ram_we_n, sram_dq_o=ram_di, sram_dq_oe=~ram_we_n.
- both selected: ROM wins, no write occurs.
- neither: sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0.
REQ-023 rom_do = ram_do = sram_dq_i at all times.
REQ-024 Before DONE the Z88 ports are ignored; ROM region is never writable from the Z88 side.
REQ-025 sram_we_n and sram_oe_n are never both low in any cycle.

Reset
REQ-026 reset_n low asynchronously forces: state IDLE, counter 0, spi_cs_n=1, spi_sck=0, spi_mosi=0, done=0, z88_reset_n=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0.
REQ-027 Reset mid-load aborts the transfer (cs_n high immediately); the load restarts from byte 0 after release.

Verification
REQ-028 Flash model with FLASH_BASE byte i = i[7:0]^8'h5A, ROM_AW=4, SCK_DIV=2 -> MOSI stream 03 10 00 00, SRAM 0x00000..0x0000F hold i^5A, done rises after 16 bytes.
REQ-029 Same load: count clk from reset release to done; must equal 1 + 32*4 + 16*(8*4+3) +/- 1 cycle.
REQ-030 After done, RAM write ram_a=19'h00123, ram_di=8'hC3, then read -> sram_a=20'h80123, ram_do=8'hC3; ROM read rom_a=0x00005 -> rom_do=8'h5F.
REQ-031 rom_ce_n=0 and ram_ce_n=0 with ram_we_n=0 -> sram_we_n=1, sram_a[19]=0, no SRAM contents change.
REQ-032 reset_n pulsed low during byte 7 -> cs_n high same cycle, z88_reset_n stays 0, new 03 command issued, final image complete and correct.
REQ-033 All runs: assertion that sram_we_n and sram_oe_n never both low, and z88_reset_n=0 whenever done=0.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: copies a ROM image from SPI flash (mode 0, single READ command)
// into the low half of an external async SRAM while holding the Z88 in reset,
// then releases the Z88 and hands it a combinational ROM/RAM path to the SRAM.
module rom_loader #(
   parameter logic [23:0] FLASH_BASE = 24'h100000,
   parameter int unsigned ROM_AW     = 19,
   parameter int unsigned SCK_DIV    = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        z88_reset_n,
   output logic        done,
   input  logic [18:0] rom_a,
   input  logic        rom_ce_n,
   input  logic        rom_oe_n,
   output logic [7:0]  rom_do,
   input  logic [18:0] ram_a,
   input  logic [7:0]  ram_di,
   input  logic        ram_ce_n,
   input  logic        ram_oe_n,
   input  logic        ram_we_n,
   output logic [7:0]  ram_do,
   output logic [19:0] sram_a,
   output logic [7:0]  sram_dq_o,
   input  logic [7:0]  sram_dq_i,
   output logic        sram_dq_oe,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n
);

   typedef enum logic [2:0] {IDLE, CMD, READ, WRITE, DONE} state_t;

   localparam logic [31:0]       CMD_WORD = {8'h03, FLASH_BASE};
   localparam logic [7:0]        DIV_LAST = 8'(SCK_DIV - 1);
   localparam logic [ROM_AW-1:0] CNT_LAST = '1;
   localparam logic [ROM_AW-1:0] CNT_ONE  = ROM_AW'(1);

   state_t            state_q, state_d;
   logic [7:0]        div_q, div_d;
   logic              sck_q, sck_d;
   logic              cs_n_q, cs_n_d;
   logic              mosi_q, mosi_d;
   logic [4:0]        bit_q, bit_d;
   logic [1:0]        wr_q, wr_d;
   logic [ROM_AW-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              z88_q, z88_d;
   logic [31:0]       cmd_sr_q, cmd_sr_d;
   logic [7:0]        byte_q, byte_d;

   logic              half_end;
   logic [18:0]       cnt_ext;

   assign half_end = (div_q == DIV_LAST);
   assign cnt_ext  = 19'(cnt_q);

   assign spi_cs_n    = cs_n_q;
   assign spi_sck     = sck_q;
   assign spi_mosi    = mosi_q;
   assign done        = done_q;
   assign z88_reset_n = z88_q;
   assign rom_do      = sram_dq_i;
   assign ram_do      = sram_dq_i;

   // Control state: cleared asynchronously so a reset aborts the SPI transfer at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         sck_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         mosi_q  <= 1'b0;
         bit_q   <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         z88_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         sck_q   <= sck_d;
         cs_n_q  <= cs_n_d;
         mosi_q  <= mosi_d;
         bit_q   <= bit_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         z88_q   <= z88_d;
      end
   end

   // Shift registers for the outgoing command and incoming byte; always reloaded before use.
   always_ff @(posedge clk) begin
      cmd_sr_q <= cmd_sr_d;
      byte_q   <= byte_d;
   end

   // Load sequencer: SCK half-period timer, command/data bit counting and SRAM write pacing.
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      sck_d    = sck_q;
      cs_n_d   = cs_n_q;
      mosi_d   = mosi_q;
      bit_d    = bit_q;
      wr_d     = wr_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      z88_d    = z88_q;
      cmd_sr_d = cmd_sr_q;
      byte_d   = byte_q;
      case (state_q)
         IDLE: begin
            // First bit is presented together with chip select.
            state_d  = CMD;
            cs_n_d   = 1'b0;
            sck_d    = 1'b0;
            div_d    = '0;
            bit_d    = '0;
            cnt_d    = '0;
            mosi_d   = CMD_WORD[31];
            cmd_sr_d = {CMD_WORD[30:0], 1'b0};
         end
         CMD: begin
            if (half_end) begin
               div_d = '0;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  // Falling SCK: move MOSI to the next bit while SCK is low.
                  sck_d = 1'b0;
                  if (bit_q == 5'd31) begin
                     state_d = READ;
                     bit_d   = '0;
                     mosi_d  = 1'b0;
                  end else begin
                     bit_d    = bit_q + 5'd1;
                     mosi_d   = cmd_sr_q[31];
                     cmd_sr_d = {cmd_sr_q[30:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         READ: begin
            if (half_end) begin
               div_d = '0;
               if (!sck_q) begin
                  sck_d  = 1'b1;
                  byte_d = {byte_q[6:0], spi_miso};
               end else begin
                  sck_d = 1'b0;
                  if (bit_q == 5'd7) begin
                     state_d = WRITE;
                     bit_d   = '0;
                     wr_d    = '0;
                  end else begin
                     bit_d = bit_q + 5'd1;
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         WRITE: begin
            // Two cycles of write strobe, one of data hold with strobe released.
            if (wr_q == 2'd2) begin
               wr_d  = '0;
               cnt_d = cnt_q + CNT_ONE;
               div_d = '0;
               if (cnt_q == CNT_LAST) begin
                  state_d = DONE;
                  cs_n_d  = 1'b1;
                  done_d  = 1'b1;
                  z88_d   = 1'b1;
               end else begin
                  state_d = READ;
               end
            end else begin
               wr_d = wr_q + 2'd1;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // SRAM port: loader writes before completion, Z88 pass-through afterwards (ROM has priority, never written).
   always_comb begin
      sram_a     = '0;
      sram_dq_o  = '0;
      sram_dq_oe = 1'b0;
      sram_ce_n  = 1'b1;
      sram_oe_n  = 1'b1;
      sram_we_n  = 1'b1;
      if (state_q == WRITE) begin
         sram_a     = {1'b0, cnt_ext};
         sram_dq_o  = byte_q;
         sram_dq_oe = 1'b1;
         sram_ce_n  = 1'b0;
         sram_we_n  = (wr_q == 2'd2);
      end else if (state_q == DONE) begin
         if (!rom_ce_n) begin
            sram_a    = {1'b0, rom_a};
            sram_ce_n = 1'b0;
            sram_oe_n = rom_oe_n;
         end else if (!ram_ce_n) begin
            sram_a     = {1'b1, ram_a};
            sram_ce_n  = 1'b0;
            // A write request suppresses output enable so OE and WE are never both active.
            sram_oe_n  = ram_oe_n | ~ram_we_n;
            sram_we_n  = ram_we_n;
            sram_dq_o  = ram_di;
            sram_dq_oe = ~ram_we_n;
         end
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: SPI flash and async SRAM models around rom_loader, a per-cycle
// compare process against a behavioural model, and directed scenarios.
module tb_rom_loader;

   localparam logic [23:0] FLASH_BASE_TB = 24'h100000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        spi_cs_n, spi_sck, spi_mosi;
   logic        spi_miso = 1'b0;
   logic        z88_reset_n, done;
   logic [18:0] rom_a, ram_a;
   logic        rom_ce_n, rom_oe_n;
   logic [7:0]  rom_do, ram_do, ram_di;
   logic        ram_ce_n, ram_oe_n, ram_we_n;
   logic [19:0] sram_a;
   logic [7:0]  sram_dq_o, sram_dq_i;
   logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

   rom_loader #(.FLASH_BASE(FLASH_BASE_TB), .ROM_AW(4), .SCK_DIV(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .z88_reset_n(z88_reset_n), .done(done),
      .rom_a(rom_a), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .rom_do(rom_do),
      .ram_a(ram_a), .ram_di(ram_di), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
      .ram_we_n(ram_we_n), .ram_do(ram_do),
      .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;

   int tot_m = 0, bad_m = 0;
   int tot_c = 0, bad_c = 0;

   task automatic chk_m(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_m++;
      if (act !== exp) begin
         bad_m++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_c(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_c++;
      if (act !== exp) begin
         bad_c++;
         $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   // SPI flash model: collects the command, then streams byte (addr-FLASH_BASE)^5A MSB first.
   int          nbits = 0;
   int          cmd_count = 0;
   logic [31:0] cmd_rx = '0;
   logic [31:0] cmd_last = '0;
   always @(posedge spi_sck or posedge spi_cs_n) begin
      if (spi_cs_n) begin
         nbits  = 0;
         cmd_rx = '0;
      end else begin
         if (nbits < 32) cmd_rx = {cmd_rx[30:0], spi_mosi};
         if (nbits == 31) begin
            cmd_last = cmd_rx;
            cmd_count++;
         end
         nbits++;
      end
   end

   int          fk;
   logic [23:0] foff;
   logic [7:0]  fbyte;
   always @(negedge spi_sck) begin
      if (!spi_cs_n && nbits >= 32) begin
         fk       = nbits - 32;
         foff     = cmd_last[23:0] + 24'(fk / 8) - FLASH_BASE_TB;
         fbyte    = foff[7:0] ^ 8'h5A;
         spi_miso = fbyte[7 - (fk % 8)];
      end
   end

   // Async SRAM model (write sampled on clk while strobed); bench may request clearing the image area.
   logic [7:0] mem [0:(1<<20)-1];
   int         clr_gen = 1;
   int         clr_seen = 0;
   always @(posedge clk) begin
      if (clr_seen != clr_gen) begin
         for (int i = 0; i < 32; i++) mem[i] = 8'h00;
         clr_seen = clr_gen;
      end
      if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_a] = sram_dq_o;
   end
   assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 8'h00;

   // Per-cycle compare: load writes follow byte index i -> (addr i, data i^5A); after done, Z88 mapping rules.
   int   load_idx = 0;
   logic we_prev = 1'b1;
   logic [19:0] e_a;
   logic e_ce, e_oe, e_we, e_oe_dq;
   always @(negedge clk) begin
      if (!reset_n) begin
         load_idx = 0;
         we_prev  = 1'b1;
      end else begin
         chk_c("rom_do_path", 32'(rom_do), 32'(sram_dq_i));
         chk_c("ram_do_path", 32'(ram_do), 32'(sram_dq_i));
         chk_c("we_oe_exclusive", 32'(sram_we_n | sram_oe_n), 32'd1);
         chk_c("z88_follows_done", 32'(z88_reset_n), 32'(done));
         if (!done) begin
            chk_c("load_oe_n", 32'(sram_oe_n), 32'd1);
            if (!sram_we_n) begin
               chk_c("load_addr", 32'(sram_a), 32'(20'(load_idx)));
               chk_c("load_data", 32'(sram_dq_o), 32'(8'(load_idx) ^ 8'h5A));
               chk_c("load_dq_oe", 32'(sram_dq_oe), 32'd1);
               chk_c("load_ce_n", 32'(sram_ce_n), 32'd0);
            end
            if (sram_we_n && !we_prev) load_idx++;
         end else begin
            e_a = '0;
            if (!rom_ce_n) begin
               e_a = {1'b0, rom_a}; e_ce = 1'b0; e_oe = rom_oe_n; e_we = 1'b1; e_oe_dq = 1'b0;
            end else if (!ram_ce_n) begin
               e_a = {1'b1, ram_a}; e_ce = 1'b0; e_oe = ram_oe_n; e_we = ram_we_n; e_oe_dq = ~ram_we_n;
            end else begin
               e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_oe_dq = 1'b0;
            end
            chk_c("pt_ce_n", 32'(sram_ce_n), 32'(e_ce));
            chk_c("pt_oe_n", 32'(sram_oe_n), 32'(e_oe));
            chk_c("pt_we_n", 32'(sram_we_n), 32'(e_we));
            chk_c("pt_dq_oe", 32'(sram_dq_oe), 32'(e_oe_dq));
            if (!e_ce) chk_c("pt_addr", 32'(sram_a), 32'(e_a));
            if (e_oe_dq) chk_c("pt_dq_o", 32'(sram_dq_o), 32'(ram_di));
         end
         we_prev = sram_we_n;
      end
   end

   task automatic idle_z88();
      rom_a = '0; rom_ce_n = 1'b1; rom_oe_n = 1'b1;
      ram_a = '0; ram_di = '0; ram_ce_n = 1'b1; ram_oe_n = 1'b1; ram_we_n = 1'b1;
   endtask

   task automatic check_image(input string tag);
      for (int i = 0; i < 16; i++)
         chk_m({tag, "_image"}, 32'(mem[i]), 32'(8'(i) ^ 8'h5A));
      chk_m({tag, "_no_extra_byte"}, 32'(mem[16]), 32'h00);
      chk_m({tag, "_byte_count"}, 32'(load_idx), 32'd16);
   endtask

   int cyc;

   initial begin
      reset_n = 1'b0;
      idle_z88();
      repeat (3) @(posedge clk);
      #1;
      chk_m("rst_cs_n", 32'(spi_cs_n), 32'd1);
      chk_m("rst_sck", 32'(spi_sck), 32'd0);
      chk_m("rst_mosi", 32'(spi_mosi), 32'd0);
      chk_m("rst_done", 32'(done), 32'd0);
      chk_m("rst_z88", 32'(z88_reset_n), 32'd0);
      chk_m("rst_sram_ce_n", 32'(sram_ce_n), 32'd1);
      chk_m("rst_sram_oe_n", 32'(sram_oe_n), 32'd1);
      chk_m("rst_sram_we_n", 32'(sram_we_n), 32'd1);
      chk_m("rst_dq_oe", 32'(sram_dq_oe), 32'd0);

      // First load: timed from release; 1 + 32*4 + 16*(8*4+3) = 689 cycles.
      @(negedge clk);
      reset_n = 1'b1;
      cyc = 0;
      while (!done && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      $display("first load took %0d cycles", cyc);
      chk_m("load_cycles_689pm1", 32'(cyc >= 688 && cyc <= 690), 32'd1);
      chk_m("cmd_word", cmd_last, 32'h03100000);
      chk_m("cmd_count_1", 32'(cmd_count), 32'd1);
      chk_m("byte0_lit", 32'(mem[0]), 32'h5A);
      chk_m("byte15_lit", 32'(mem[15]), 32'h55);
      check_image("load1");
      chk_m("done_cs_n", 32'(spi_cs_n), 32'd1);
      chk_m("done_sck", 32'(spi_sck), 32'd0);
      chk_m("done_z88", 32'(z88_reset_n), 32'd1);

      // RAM write then read back through the upper half.
      @(posedge clk); #1;
      ram_a = 19'h00123; ram_di = 8'hC3; ram_ce_n = 1'b0; ram_we_n = 1'b0; ram_oe_n = 1'b1;
      #1;
      chk_m("ram_wr_addr", 32'(sram_a), 32'h80123);
      chk_m("ram_wr_we_n", 32'(sram_we_n), 32'd0);
      chk_m("ram_wr_dq", 32'(sram_dq_o), 32'hC3);
      @(posedge clk); #1;
      ram_we_n = 1'b1; ram_oe_n = 1'b0;
      #1;
      chk_m("ram_rd_addr", 32'(sram_a), 32'h80123);
      chk_m("ram_rd_data", 32'(ram_do), 32'hC3);
      // ROM read of byte 5.
      ram_ce_n = 1'b1; ram_oe_n = 1'b1;
      rom_a = 19'h00005; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
      #1;
      chk_m("rom_rd_addr", 32'(sram_a), 32'h00005);
      chk_m("rom_rd_data", 32'(rom_do), 32'h5F);
      // Both selected with a RAM write request: ROM wins, nothing written.
      rom_a = 19'h00003; rom_oe_n = 1'b1;
      ram_a = 19'h00003; ram_di = 8'hAA; ram_ce_n = 1'b0; ram_we_n = 1'b0;
      #1;
      chk_m("both_we_n", 32'(sram_we_n), 32'd1);
      chk_m("both_a19", 32'(sram_a[19]), 32'd0);
      chk_m("both_dq_oe", 32'(sram_dq_oe), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      idle_z88();
      #1;
      chk_m("both_rom_intact", 32'(mem[3]), 32'h59);
      chk_m("both_ram_intact", 32'(mem[20'h80123]), 32'hC3);
      chk_m("idle_ce_n", 32'(sram_ce_n), 32'd1);

      // Reset from DONE, reload with Z88 write requests active, abort during byte 7.
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk_m("rst2_done", 32'(done), 32'd0);
      chk_m("rst2_z88", 32'(z88_reset_n), 32'd0);
      chk_m("rst2_cs_n", 32'(spi_cs_n), 32'd1);
      clr_gen++;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      ram_a = 19'h00007; ram_di = 8'hFF; ram_ce_n = 1'b0; ram_we_n = 1'b0; ram_oe_n = 1'b1;
      cyc = 0;
      while (load_idx < 7 && cyc < 3000) begin
         @(posedge clk);
         cyc++;
      end
      chk_m("reach_byte7", 32'(load_idx), 32'd7);
      repeat (10) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk_m("abort_cs_n", 32'(spi_cs_n), 32'd1);
      chk_m("abort_sck", 32'(spi_sck), 32'd0);
      chk_m("abort_z88", 32'(z88_reset_n), 32'd0);
      chk_m("abort_done", 32'(done), 32'd0);
      chk_m("abort_we_n", 32'(sram_we_n), 32'd1);
      clr_gen++;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      cyc = 0;
      while (!done && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk_m("reload_done", 32'(done), 32'd1);
      chk_m("reload_cmd_word", cmd_last, 32'h03100000);
      chk_m("reload_cmd_count", 32'(cmd_count), 32'd3);
      check_image("load2");
      idle_z88();
      repeat (3) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", tot_m + tot_c, bad_m + bad_c);
      $finish;
   end

endmodule
